// File: rtl/data_pattern_check.sv
// Receive-side checker for fval/lval pixel streams (PIX_INC / LINE_INC / FRAME_INC patterns).
// Optional first-mismatch position capture is enabled by defining DATA_PATTERN_CHECK_ERR_POS_EN.
module data_pattern_check #(
    parameter string       CHECK_MODE = "PIX_INC",
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clr,
    input  logic                  i_fval,
    input  logic                  i_lval,
    input  logic [DATA_WIDTH-1:0] iv_din,
    output logic                  o_err,
    output logic                  o_err_sticky,
    output logic [CNT_WIDTH-1:0]  ov_err_cnt,
    output logic [DATA_WIDTH-1:0] ov_first_exp,
    output logic [DATA_WIDTH-1:0] ov_first_act,
    output logic                  o_proto_err,
    output logic [CNT_WIDTH-1:0]  ov_frame_cnt,
    output logic [CNT_WIDTH-1:0]  ov_lines,
    output logic [CNT_WIDTH-1:0]  ov_pixels,
    output logic                  o_frame_done
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
    ,
    output logic [CNT_WIDTH-1:0]  ov_err_line,
    output logic [CNT_WIDTH-1:0]  ov_err_pix,
    output logic [CNT_WIDTH-1:0]  ov_err_frame
`endif
);

    localparam int unsigned MODE_PIX   = 0;
    localparam int unsigned MODE_LINE  = 1;
    localparam int unsigned MODE_FRAME = 2;
    localparam int unsigned MODE_BAD   = 3;
    localparam int unsigned MODE = (CHECK_MODE == "PIX_INC")   ? MODE_PIX   :
                                   (CHECK_MODE == "LINE_INC")  ? MODE_LINE  :
                                   (CHECK_MODE == "FRAME_INC") ? MODE_FRAME : MODE_BAD;

    // Elaboration-time parameter checks.
    generate
        if (MODE == MODE_BAD) begin : g_bad_mode
            $error("data_pattern_check: CHECK_MODE must be PIX_INC, LINE_INC or FRAME_INC");
        end
        if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_width
            $error("data_pattern_check: DATA_WIDTH must be 8..32");
        end
        if (MODE == MODE_LINE && DATA_WIDTH < 5) begin : g_bad_line_width
            $error("data_pattern_check: LINE_INC needs DATA_WIDTH >= 5");
        end
    endgenerate

    // Every flop of the checker; reset and i_clr both return it to all-zero.
    typedef struct packed {
        logic                  s1_fval;
        logic                  s1_lval;
        logic [DATA_WIDTH-1:0] s1_din;
        logic                  prev_fval;
        logic                  prev_lv;
        logic [CNT_WIDTH-1:0]  pix_cnt;
        logic [CNT_WIDTH-1:0]  line_cnt;
        logic [CNT_WIDTH-1:0]  last_pix;
        logic [DATA_WIDTH-1:0] pix_exp;
        logic [DATA_WIDTH-1:0] frame_val;
        logic                  seeded;
        logic                  err;
        logic                  err_sticky;
        logic [CNT_WIDTH-1:0]  err_cnt;
        logic [DATA_WIDTH-1:0] first_exp;
        logic [DATA_WIDTH-1:0] first_act;
        logic                  proto_err;
        logic [CNT_WIDTH-1:0]  frame_cnt;
        logic [CNT_WIDTH-1:0]  lines;
        logic [CNT_WIDTH-1:0]  pixels;
        logic                  frame_done;
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
        logic [CNT_WIDTH-1:0]  err_line;
        logic [CNT_WIDTH-1:0]  err_pix;
        logic [CNT_WIDTH-1:0]  err_frame;
`endif
    } state_t;

    state_t st;
    state_t st_n;

    logic                  lv_c;
    logic                  lv_rise_c;
    logic                  lv_fall_c;
    logic                  fval_fall_c;
    logic                  seed_c;
    logic                  mismatch_c;
    logic [CNT_WIDTH-1:0]  cur_pix_c;
    logic [DATA_WIDTH-1:0] exp_c;

    // Stage-2 decode: edges, current pixel index, expected value and compare.
    always_comb begin
        lv_c        = st.s1_fval & st.s1_lval;
        lv_rise_c   = lv_c & ~st.prev_lv;
        lv_fall_c   = st.prev_lv & ~lv_c;
        fval_fall_c = st.prev_fval & ~st.s1_fval;
        cur_pix_c   = lv_rise_c ? '0 : st.pix_cnt;
        if (MODE == MODE_LINE) begin
            exp_c = (DATA_WIDTH'(st.line_cnt) << 4) | DATA_WIDTH'(cur_pix_c[3:0]);
        end else if (MODE == MODE_FRAME) begin
            exp_c = st.frame_val;
        end else begin
            exp_c = st.pix_exp;
        end
        seed_c     = (MODE == MODE_FRAME) && lv_c && !st.seeded;
        mismatch_c = lv_c && !seed_c && (st.s1_din != exp_c);
    end

    // Next-state: stage-1 capture, error/geometry reporting and tracking.
    always_comb begin
        st_n = st;

        st_n.s1_fval    = i_fval;
        st_n.s1_lval    = i_lval;
        st_n.s1_din     = iv_din;
        st_n.prev_fval  = st.s1_fval;
        st_n.prev_lv    = lv_c;
        st_n.err        = mismatch_c;
        st_n.proto_err  = st.proto_err | (st.s1_lval & ~st.s1_fval);
        st_n.frame_done = fval_fall_c;

        if (mismatch_c) begin
            st_n.err_sticky = 1'b1;
            if (st.err_cnt != '1) begin
                st_n.err_cnt = st.err_cnt + CNT_WIDTH'(1);
            end
            if (!st.err_sticky) begin
                st_n.first_exp = exp_c;
                st_n.first_act = st.s1_din;
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
                st_n.err_line  = st.line_cnt;
                st_n.err_pix   = cur_pix_c;
                st_n.err_frame = st.frame_cnt;
`endif
            end
        end

        // A line still open at the fval fall counts as the frame's final line.
        if (fval_fall_c) begin
            st_n.frame_cnt = st.frame_cnt + CNT_WIDTH'(1);
            st_n.lines     = st.line_cnt + CNT_WIDTH'(st.prev_lv);
            st_n.pixels    = st.prev_lv ? st.pix_cnt : st.last_pix;
        end

        if (!st.s1_fval) begin
            st_n.pix_cnt  = '0;
            st_n.line_cnt = '0;
            st_n.last_pix = '0;
            st_n.pix_exp  = '0;
        end else begin
            if (lv_c) begin
                st_n.pix_cnt = cur_pix_c + CNT_WIDTH'(1);
                st_n.pix_exp = st.pix_exp + DATA_WIDTH'(1);
            end
            if (lv_fall_c) begin
                st_n.line_cnt = st.line_cnt + CNT_WIDTH'(1);
                st_n.last_pix = st.pix_cnt;
            end
        end

        // FRAME_INC advances once per frame after seeding, match or not.
        if (seed_c) begin
            st_n.frame_val = st.s1_din;
            st_n.seeded    = 1'b1;
        end else if (fval_fall_c && st.seeded) begin
            st_n.frame_val = st.frame_val + DATA_WIDTH'(1);
        end

        if (i_clr) begin
            st_n = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= '0;
        end else begin
            st <= st_n;
        end
    end

    assign o_err        = st.err;
    assign o_err_sticky = st.err_sticky;
    assign ov_err_cnt   = st.err_cnt;
    assign ov_first_exp = st.first_exp;
    assign ov_first_act = st.first_act;
    assign o_proto_err  = st.proto_err;
    assign ov_frame_cnt = st.frame_cnt;
    assign ov_lines     = st.lines;
    assign ov_pixels    = st.pixels;
    assign o_frame_done = st.frame_done;
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
    assign ov_err_line  = st.err_line;
    assign ov_err_pix   = st.err_pix;
    assign ov_err_frame = st.err_frame;
`endif

endmodule

// File: tb/tb_data_pattern_check.sv
// Scoreboard bench for data_pattern_check: PIX_INC, LINE_INC, FRAME_INC (12-bit) and PIX_INC (8-bit).
module tb_data_pattern_check;

    localparam int unsigned DW = 12;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [CW-1:0] lines;
        logic [CW-1:0] pixels;
    } geo_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_clr = 1'b0;
    logic          i_fval = 1'b0;
    logic          i_lval = 1'b0;
    logic [DW-1:0] din = '0;

    logic          err_a  [4];
    logic          stk_a  [4];
    logic          prot_a [4];
    logic          done_a [4];
    logic [CW-1:0] cnt_a  [4];
    logic [CW-1:0] fcnt_a [4];
    logic [CW-1:0] lin_a  [4];
    logic [CW-1:0] pxl_a  [4];
    logic [DW-1:0] fe_a   [4];
    logic [DW-1:0] fa_a   [4];
    logic [7:0]    fe8;
    logic [7:0]    fa8;
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
    logic [CW-1:0] el_a [4];
    logic [CW-1:0] ep_a [4];
    logic [CW-1:0] ef_a [4];
`endif

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam string M = (i == 0) ? "PIX_INC" : ((i == 1) ? "LINE_INC" : "FRAME_INC");
        data_pattern_check #(.CHECK_MODE(M), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
            .clk(clk), .reset_n(reset_n), .i_clr(i_clr), .i_fval(i_fval), .i_lval(i_lval),
            .iv_din(din), .o_err(err_a[i]), .o_err_sticky(stk_a[i]), .ov_err_cnt(cnt_a[i]),
            .ov_first_exp(fe_a[i]), .ov_first_act(fa_a[i]), .o_proto_err(prot_a[i]),
            .ov_frame_cnt(fcnt_a[i]), .ov_lines(lin_a[i]), .ov_pixels(pxl_a[i]),
            .o_frame_done(done_a[i])
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
            , .ov_err_line(el_a[i]), .ov_err_pix(ep_a[i]), .ov_err_frame(ef_a[i])
`endif
        );
    end

    data_pattern_check #(.CHECK_MODE("PIX_INC"), .DATA_WIDTH(8), .CNT_WIDTH(CW)) u_pix8 (
        .clk(clk), .reset_n(reset_n), .i_clr(i_clr), .i_fval(i_fval), .i_lval(i_lval),
        .iv_din(din[7:0]), .o_err(err_a[3]), .o_err_sticky(stk_a[3]), .ov_err_cnt(cnt_a[3]),
        .ov_first_exp(fe8), .ov_first_act(fa8), .o_proto_err(prot_a[3]),
        .ov_frame_cnt(fcnt_a[3]), .ov_lines(lin_a[3]), .ov_pixels(pxl_a[3]),
        .o_frame_done(done_a[3])
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
        , .ov_err_line(el_a[3]), .ov_err_pix(ep_a[3]), .ov_err_frame(ef_a[3])
`endif
    );
    assign fe_a[3] = DW'(fe8);
    assign fa_a[3] = DW'(fa8);

    int            sel = 0;
    logic          m_err, m_stk, m_prot, m_done;
    logic [CW-1:0] m_cnt, m_fcnt, m_lin, m_pxl;
    logic [DW-1:0] m_fe, m_fa;

    always_comb begin
        m_err  = err_a[sel];
        m_stk  = stk_a[sel];
        m_prot = prot_a[sel];
        m_done = done_a[sel];
        m_cnt  = cnt_a[sel];
        m_fcnt = fcnt_a[sel];
        m_lin  = lin_a[sel];
        m_pxl  = pxl_a[sel];
        m_fe   = fe_a[sel];
        m_fa   = fa_a[sel];
    end

    bit   exp_err_q[$];
    geo_t geo_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Input-side delay line marking when a pixel / frame end should reach the outputs.
    logic v1, v2, pf, f1, f2;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0; v2 <= 1'b0; pf <= 1'b0; f1 <= 1'b0; f2 <= 1'b0;
        end else begin
            v1 <= i_fval & i_lval;
            v2 <= v1;
            pf <= i_fval;
            f1 <= pf & ~i_fval;
            f2 <= f1;
        end
    end

    // Monitor: pops the scoreboard whenever a pixel result or frame end is due.
    always @(negedge clk) begin
        if (reset_n) begin
            if (v2) begin
                if (exp_err_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL err_scoreboard_underflow: got o_err=%0b with no expectation", m_err);
                end else begin
                    chk("o_err", 32'(m_err), 32'(exp_err_q.pop_front()));
                end
            end else if (m_err) begin
                chk("o_err_spurious", 32'(m_err), 32'd0);
            end
            if (f2) begin
                if (geo_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL geo_scoreboard_underflow: got frame_done=%0b with no expectation", m_done);
                end else begin
                    geo_t g;
                    g = geo_q.pop_front();
                    chk("o_frame_done", 32'(m_done), 32'd1);
                    chk("ov_frame_cnt", 32'(m_fcnt), 32'(g.cnt));
                    chk("ov_lines", 32'(m_lin), 32'(g.lines));
                    chk("ov_pixels", 32'(m_pxl), 32'(g.pixels));
                end
            end else if (m_done) begin
                chk("frame_done_spurious", 32'(m_done), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit f, input bit l, input logic [DW-1:0] d, input bit e);
        i_fval = f;
        i_lval = l;
        din    = d;
        if (f && l) exp_err_q.push_back(e);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, DW'(0), 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_fval = 1'b0; i_lval = 1'b0; din = '0; i_clr = 1'b0;
        #1;
        exp_err_q.delete();
        geo_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    // mode 0 PIX_INC, 1 LINE_INC, 2 FRAME_INC (every pixel sent as fsend, expected fexp).
    task automatic send_frame(input int mode, input int nl, input int np, input int fexp,
                              input int fsend, input int bl, input int bp, input int bv,
                              input int mask, input bit tight, input int cnt);
        int e;
        int s;
        drive(1'b1, 1'b0, DW'(0), 1'b0);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < np; p++) begin
                if (mode == 0)      e = (l * np + p) & mask;
                else if (mode == 1) e = ((l << 4) | (p & 15)) & mask;
                else                e = fexp;
                s = (mode == 2) ? fsend : ((l == bl && p == bp) ? bv : e);
                drive(1'b1, 1'b1, DW'(s), s != e);
            end
            if (!(tight && l == nl - 1)) begin
                drive(1'b1, 1'b0, DW'(0), 1'b0);
                drive(1'b1, 1'b0, DW'(0), 1'b0);
            end
        end
        geo_q.push_back('{CW'(cnt), CW'(nl), CW'((nl == 0) ? 0 : np)});
        idle(5);
    endtask

    initial begin
        // Reset state and clean PIX_INC frame, then an empty frame.
        sel = 0;
        do_reset();
        chk("reset_err_cnt", 32'(m_cnt), 32'd0);
        chk("reset_sticky", 32'(m_stk), 32'd0);
        chk("reset_frame_cnt", 32'(m_fcnt), 32'd0);
        chk("reset_proto", 32'(m_prot), 32'd0);
        send_frame(0, 3, 8, 0, 0, -1, -1, 0, 32'hFFF, 1'b0, 1);
        chk("pix_clean_err_cnt", 32'(m_cnt), 32'd0);
        chk("pix_clean_sticky", 32'(m_stk), 32'd0);
        send_frame(0, 0, 8, 0, 0, -1, -1, 0, 32'hFFF, 1'b0, 2);

        // PIX_INC single bad pixel, then synchronous clear.
        do_reset();
        send_frame(0, 3, 8, 0, 0, 1, 5, 32'h0AA, 32'hFFF, 1'b0, 1);
        chk("pix_bad_err_cnt", 32'(m_cnt), 32'd1);
        chk("pix_bad_sticky", 32'(m_stk), 32'd1);
        chk("pix_bad_first_exp", 32'(m_fe), 32'd13);
        chk("pix_bad_first_act", 32'(m_fa), 32'h0AA);
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
        chk("pix_bad_err_line", 32'(el_a[0]), 32'd1);
        chk("pix_bad_err_pix", 32'(ep_a[0]), 32'd5);
        chk("pix_bad_err_frame", 32'(ef_a[0]), 32'd0);
`endif
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("clr_err_cnt", 32'(m_cnt), 32'd0);
        chk("clr_sticky", 32'(m_stk), 32'd0);
        chk("clr_first_exp", 32'(m_fe), 32'd0);
        chk("clr_frame_cnt", 32'(m_fcnt), 32'd0);
        chk("clr_lines", 32'(m_lin), 32'd0);
`ifdef DATA_PATTERN_CHECK_ERR_POS_EN
        chk("clr_err_line", 32'(el_a[0]), 32'd0);
`endif
        send_frame(0, 2, 4, 0, 0, -1, -1, 0, 32'hFFF, 1'b0, 1);

        // LINE_INC clean 4x20, then one wrong pixel at line 2 pixel 17.
        sel = 1;
        do_reset();
        send_frame(1, 4, 20, 0, 0, -1, -1, 0, 32'hFFF, 1'b0, 1);
        chk("line_clean_err_cnt", 32'(m_cnt), 32'd0);
        send_frame(1, 4, 20, 0, 0, 2, 17, 32'h031, 32'hFFF, 1'b0, 2);
        chk("line_bad_err_cnt", 32'(m_cnt), 32'd1);
        chk("line_bad_first_exp", 32'(m_fe), 32'h021);
        chk("line_bad_first_act", 32'(m_fa), 32'h031);

        // FRAME_INC: seed 7, pass 8, 10 against expected 9, then 10 passes.
        sel = 2;
        do_reset();
        send_frame(2, 2, 4, 7, 7, -1, -1, 0, 32'hFFF, 1'b0, 1);
        send_frame(2, 2, 4, 8, 8, -1, -1, 0, 32'hFFF, 1'b0, 2);
        chk("frm_pass_err_cnt", 32'(m_cnt), 32'd0);
        send_frame(2, 2, 4, 9, 10, -1, -1, 0, 32'hFFF, 1'b0, 3);
        chk("frm_bad_err_cnt", 32'(m_cnt), 32'd8);
        chk("frm_bad_first_exp", 32'(m_fe), 32'd9);
        chk("frm_bad_first_act", 32'(m_fa), 32'd10);
        send_frame(2, 2, 4, 10, 10, -1, -1, 0, 32'hFFF, 1'b0, 4);
        chk("frm_advance_err_cnt", 32'(m_cnt), 32'd8);

        // 8-bit PIX_INC wrap over 300 pixels, fval and lval dropping together.
        sel = 3;
        do_reset();
        send_frame(0, 1, 300, 0, 0, -1, -1, 0, 32'hFF, 1'b1, 1);
        chk("pix8_wrap_err_cnt", 32'(m_cnt), 32'd0);

        // Protocol error, then asynchronous reset mid-frame and a clean frame after.
        sel = 0;
        do_reset();
        drive(1'b0, 1'b1, DW'(0), 1'b0);
        idle(3);
        chk("proto_err", 32'(m_prot), 32'd1);
        send_frame(0, 2, 4, 0, 0, 0, 2, 7, 32'hFFF, 1'b0, 1);
        chk("pre_reset_err_cnt", 32'(m_cnt), 32'd1);
        drive(1'b1, 1'b0, DW'(0), 1'b0);
        drive(1'b1, 1'b1, DW'(0), 1'b0);
        drive(1'b1, 1'b1, DW'(1), 1'b0);
        reset_n = 1'b0;
        #1;
        exp_err_q.delete();
        geo_q.delete();
        chk("mid_reset_err", 32'(m_err), 32'd0);
        chk("mid_reset_sticky", 32'(m_stk), 32'd0);
        chk("mid_reset_err_cnt", 32'(m_cnt), 32'd0);
        chk("mid_reset_first_exp", 32'(m_fe), 32'd0);
        chk("mid_reset_first_act", 32'(m_fa), 32'd0);
        chk("mid_reset_proto", 32'(m_prot), 32'd0);
        chk("mid_reset_frame_cnt", 32'(m_fcnt), 32'd0);
        chk("mid_reset_lines", 32'(m_lin), 32'd0);
        chk("mid_reset_pixels", 32'(m_pxl), 32'd0);
        chk("mid_reset_done", 32'(m_done), 32'd0);
        i_fval = 1'b0; i_lval = 1'b0; din = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        send_frame(0, 2, 4, 0, 0, -1, -1, 0, 32'hFFF, 1'b0, 1);
        chk("post_reset_err_cnt", 32'(m_cnt), 32'd0);
        chk("post_reset_queue_empty", 32'(exp_err_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
